// File: rtl/freq_display_ctrl.sv
// Display scheduler for the frequency counter: serial double-dabble BCD conversion of each
// 32-bit result plus overflow, kHz decimal point, stale-timeout and hold handling.
module freq_display_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] count,
    input  logic        count_valid,
    input  logic        unit_sel,
    input  logic        hold,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [3:0]  digit5,
    output logic [3:0]  digit6,
    output logic [3:0]  digit7,
    output logic        dp0,
    output logic        dp1,
    output logic        dp2,
    output logic        dp3,
    output logic        dp4,
    output logic        dp5,
    output logic        dp6,
    output logic        dp7,
    output logic        busy,
    output logic        update,
    output logic        overflow,
    output logic        stale,
    output logic        overrun
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] Dashes = 32'hAAAA_AAAA;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StUpdate
    } state_e;

    state_e          state_q;
    logic [31:0]     bin_q;
    logic [39:0]     bcd_q;
    logic            unit_q;
    logic [4:0]      iter_q;
    logic [31:0]     pend_count_q;
    logic            pend_unit_q;
    logic            pend_v_q;
    logic [TmoW-1:0] tmo_q;
    logic [31:0]     digits_q;
    logic [7:0]      dp_q;

    logic            accept;
    logic [39:0]     bcd_adj;
    logic            bcd_over;

    assign accept = count_valid & ~hold;

    // Add-3 correction on every nibble that would overflow a decimal digit after the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    assign bcd_over = (bcd_q[39:32] != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bin_q        <= '0;
            bcd_q        <= '0;
            unit_q       <= 1'b0;
            iter_q       <= '0;
            pend_count_q <= '0;
            pend_unit_q  <= 1'b0;
            pend_v_q     <= 1'b0;
            tmo_q        <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            update       <= 1'b0;
            overflow     <= 1'b0;
            stale        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            update  <= 1'b0;
            overrun <= 1'b0;

            // An accepted result beats a simultaneous expiry.
            if (accept) begin
                tmo_q <= '0;
            end else if (!hold && !stale) begin
                if (tmo_q == TmoLast) begin
                    stale    <= 1'b1;
                    digits_q <= Dashes;
                    dp_q     <= '0;
                    update   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_v_q) begin
                        bin_q    <= pend_count_q;
                        unit_q   <= pend_unit_q;
                        bcd_q    <= '0;
                        iter_q   <= '0;
                        state_q  <= StConvert;
                        pend_v_q <= accept;
                        if (accept) begin
                            pend_count_q <= count;
                            pend_unit_q  <= unit_sel;
                        end
                    end else if (accept) begin
                        bin_q   <= count;
                        unit_q  <= unit_sel;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    bcd_q  <= {bcd_adj[38:0], bin_q[31]};
                    bin_q  <= {bin_q[30:0], 1'b0};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd31) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    state_q <= StIdle;
                    if (!hold) begin
                        if (bcd_over) begin
                            digits_q <= Dashes;
                            dp_q     <= '0;
                            overflow <= 1'b1;
                        end else begin
                            digits_q <= bcd_q[31:0];
                            dp_q     <= {4'b0000, unit_q, 3'b000};
                            overflow <= 1'b0;
                        end
                        stale  <= 1'b0;
                        update <= 1'b1;
                        // Re-arm the timeout that was parked at its limit.
                        if (stale && !accept) begin
                            tmo_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (state_q != StIdle && accept) begin
                pend_count_q <= count;
                pend_unit_q  <= unit_sel;
                pend_v_q     <= 1'b1;
                if (pend_v_q) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != StIdle);

    assign digit0 = digits_q[3:0];
    assign digit1 = digits_q[7:4];
    assign digit2 = digits_q[11:8];
    assign digit3 = digits_q[15:12];
    assign digit4 = digits_q[19:16];
    assign digit5 = digits_q[23:20];
    assign digit6 = digits_q[27:24];
    assign digit7 = digits_q[31:28];

    assign dp0 = dp_q[0];
    assign dp1 = dp_q[1];
    assign dp2 = dp_q[2];
    assign dp3 = dp_q[3];
    assign dp4 = dp_q[4];
    assign dp5 = dp_q[5];
    assign dp6 = dp_q[6];
    assign dp7 = dp_q[7];

endmodule

// File: tb/tb_freq_display_ctrl.sv
// Scoreboard bench for freq_display_ctrl: the driver queues expected display writes and
// overrun pulses; monitors pop and compare whenever update/overrun fire.
module tb_freq_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] count = '0;
    logic        count_valid = 1'b0;
    logic        unit_sel = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic        dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7;
    logic        busy, update, overflow, stale, overrun;

    freq_display_ctrl #(
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .count_valid(count_valid),
        .unit_sel   (unit_sel),
        .hold       (hold),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .digit5     (digit5),
        .digit6     (digit6),
        .digit7     (digit7),
        .dp0        (dp0),
        .dp1        (dp1),
        .dp2        (dp2),
        .dp3        (dp3),
        .dp4        (dp4),
        .dp5        (dp5),
        .dp6        (dp6),
        .dp7        (dp7),
        .busy       (busy),
        .update     (update),
        .overflow   (overflow),
        .stale      (stale),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] disp;
    logic [7:0]  dps;
    assign disp = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};
    assign dps  = {dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0};

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic        ovf;
        logic        stl;
        int unsigned at;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned ovr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Display monitor
    always @(negedge clk) begin
        if (update) begin
            chk("update_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("digits", 64'(disp), 64'(e.digits));
                chk("dp", 64'(dps), 64'(e.dp));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("stale", 64'(stale), 64'(e.stl));
                chk("update_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Overrun monitor
    always @(negedge clk) begin
        if (overrun) begin
            chk("overrun_expected", 64'(ovr_q.size() != 0), 64'd1);
            if (ovr_q.size() != 0) begin
                int unsigned at;
                at = ovr_q.pop_front();
                chk("overrun_cycle", 64'(cyc), 64'(at));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] v, input logic u, output int unsigned t);
        count       = v;
        unit_sel    = u;
        count_valid = 1'b1;
        t           = cyc;
        tick(1);
        count_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] p, input logic o,
                        input logic s, input int unsigned at);
        exp_t e;
        e.digits = d;
        e.dp     = p;
        e.ovf    = o;
        e.stl    = s;
        e.at     = at;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    logic [31:0] vals[5] = '{32'd12345678, 32'd99999999, 32'd100000000, 32'hFFFF_FFFF, 32'd50000};
    logic        units[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] edig[5] = '{32'h1234_5678, 32'h9999_9999, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
                             32'h0005_0000};
    logic [7:0]  edp[5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    logic        eovf[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int unsigned t;
        int unsigned t0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_digits", 64'(disp), 64'd0);
        chk("rst_dp", 64'(dps), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_stale", 64'(stale), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Single conversions, including the overflow boundary and kHz point
        for (int i = 0; i < 5; i++) begin
            strobe(vals[i], units[i], t);
            chk("busy_at_t1", 64'(busy), 64'd1);
            push(edig[i], edp[i], eovf[i], 1'b0, t + 34);
            drain(60);
            tick(1);
        end

        // Pending buffer overwrite; then timeout after the last accepted strobe
        strobe(32'd11, 1'b0, t0);
        push(32'h0000_0011, 8'h00, 1'b0, 1'b0, t0 + 34);
        tick(4);
        strobe(32'd22, 1'b0, t);
        tick(4);
        strobe(32'd33, 1'b0, t);
        ovr_q.push_back(t0 + 11);
        push(32'h0000_0033, 8'h00, 1'b0, 1'b0, t0 + 68);
        push(32'hAAAA_AAAA, 8'h00, 1'b0, 1'b1, t + 65);
        drain(120);
        tick(1);

        // Fresh result clears stale
        strobe(32'd7, 1'b0, t);
        push(32'h0000_0007, 8'h00, 1'b0, 1'b0, t + 34);
        drain(60);
        tick(1);

        // Hold: strobes ignored, timeout frozen, display untouched
        hold = 1'b1;
        strobe(32'd99, 1'b0, t);
        chk("hold_busy", 64'(busy), 64'd0);
        tick(5);
        strobe(32'd98, 1'b1, t);
        tick(80);
        chk("hold_stale", 64'(stale), 64'd0);
        chk("hold_digits", 64'(disp), 64'h0000_0007);
        hold = 1'b0;

        // Reset mid-conversion
        strobe(32'd55, 1'b0, t);
        tick(9);
        rst = 1'b1;
        #2;
        chk("midrst_digits", 64'(disp), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stale", 64'(stale), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_digits", 64'(disp), 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("ovr_empty", 64'(ovr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_display_ctrl.md
# freq_display_ctrl

Display scheduler for the frequency counter. It takes each 32-bit binary frequency result, converts it to eight BCD digits with a serial double-dabble engine, and decides what the 8-digit seven-segment driver shows. It also handles range overflow, kHz decimal point placement, stale-signal timeout and display hold. It sits between the gate/count logic and the seven-segment scan driver, whose digitN/dpN inputs it drives directly.

## Interface
- TIMEOUT_CYCLES, 100000000: cycles without an accepted result before the display is marked stale (2 s at 50 MHz); must be ≥ 64.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- count  in  32  unsigned frequency result in Hz
- count_valid  in  1  one-cycle strobe; count is valid this cycle
- unit_sel  in  1  0 = Hz display, 1 = kHz display (dp3 lit); sampled with count
- hold  in  1  1 = freeze the display, ignore count_valid, freeze the timeout counter
- digit0..digit7  out  4 each  BCD digit to the driver; digit0 is least significant; 4'hA = dash
- dp0..dp7  out  1 each  decimal point enables
- busy  out  1  conversion in progress (CONVERT or UPDATE)
- update  out  1  one-cycle pulse when the digit/dp registers change
- overflow  out  1  the last displayed result exceeded 99,999,999
- stale  out  1  timeout reached; display shows dashes
- overrun  out  1  one-cycle pulse when a pending result is overwritten

## Operation
- Input capture:
  - count_valid with hold=0 is accepted and restarts the timeout counter.
  - In IDLE, the value goes straight to the conversion latch.
  - Otherwise it goes into a one-entry pending buffer {count, unit_sel, pend_v}.
  - If pend_v is already 1, the buffer is overwritten with the newest value and overrun pulses.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE → CONVERT: on an accepted count_valid, or when pend_v=1 (the pending entry is consumed and pend_v cleared).
  - CONVERT: 32 iterations, one per cycle, with iteration counter 0..31.
  - CONVERT → UPDATE: after iteration 31.
  - UPDATE → IDLE: after one cycle.
- Double-dabble arithmetic: 40-bit BCD register (10 nibbles) and 32-bit shift register.
  - Each iteration, every nibble ≥ 5 first gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The BCD register clears at CONVERT entry.
- UPDATE:
  - If BCD nibble 9 or 8 is nonzero: all digits = 4'hA, all dp = 0, overflow = 1.
  - Otherwise: digitN = nibble N, dp3 = latched unit_sel, other dp = 0, overflow = 0.
  - In both cases stale is cleared and update pulses.
  - Leading zeros are displayed as 0.
- Timeout:
  - A counter increments each cycle while hold=0 and stale=0.
  - When it reaches TIMEOUT_CYCLES−1: all digits = 4'hA, all dp = 0, stale = 1, update pulses.
  - It does not count further until the next UPDATE.
- Hold: the display registers never change. An in-flight conversion completes, but its UPDATE writes nothing and does not pulse update.

## Timing
- Reset values: all outputs 0, state IDLE, pend_v = 0, counters = 0. Reset mid-conversion aborts immediately and drops any pending data.
- Latency: count_valid at cycle T (IDLE) → busy=1 at T+1; CONVERT spans T+1..T+32; UPDATE at T+33; new digits and the update pulse are visible at T+34.
- Back-to-back: with pend_v=1 at UPDATE, the next conversion starts at the IDLE cycle immediately after (one IDLE cycle between conversions).
- Simultaneous events:
  - count_valid and timeout expiry in the same cycle: count_valid wins; the counter restarts and stale is not set.
  - Timeout expiry during CONVERT: stale is set; the following UPDATE clears it.
  - count_valid in the same cycle the pending entry is consumed: the new value goes to the buffer, pend_v = 1, no overrun.
- update and overrun are registered, single-cycle pulses.

## Test plan
- Basic conversion: count=12345678, unit_sel=0 → at T+34, digit7..0 = 1,2,3,4,5,6,7,8; all dp=0; update=1 for one cycle; overflow=0.
- Overflow boundary:
  - count=99999999 → digits all 9, overflow=0.
  - count=100000000 → digits all 4'hA, overflow=1.
  - count=32'hFFFFFFFF → all 4'hA, overflow=1.
- kHz decimal point: count=50000, unit_sel=1 → digits 00050000, dp3=1, other dp=0.
- Pending and overrun: three strobes at T, T+5, T+10 carrying 11, 22, 33 → overrun pulses at T+11; displays 11 at T+34, then 33; 22 is never shown.
- Timeout and stale (TIMEOUT_CYCLES=64): no strobe after one update → 64 cycles later stale=1 and all digits 4'hA; the next strobe of 7 → digits 00000007, stale=0.
- Hold and reset:
  - hold=1 with strobes applied → no update pulses, digits unchanged.
  - rst asserted at T+10 of a conversion → all outputs 0, state IDLE; no update follows.
